// File: rtl/axis_divider.sv
// rtl/axis_divider.sv - iterative radix-2 integer divider with valid-only stream handshake
//
// Computes quotient and remainder of dividend / divisor using one restoring
// shift-subtract step per clock. Fixed latency: the result strobe is visible
// in the cycle after the (WIDTH+1)th edge following acceptance.
//
// Build option: define DIVIDER_SIGNED_EN for two's-complement operands
// (quotient truncates toward zero, remainder takes the dividend's sign).
// Left undefined, operands are unsigned.
//
// Ports:
//   aclk                   clock, rising edge
//   rst                    synchronous active-high reset
//   s_axis_dividend_tvalid dividend valid
//   s_axis_dividend_tdata  dividend [WIDTH-1:0]
//   s_axis_divisor_tvalid  divisor valid
//   s_axis_divisor_tdata   divisor [WIDTH-1:0]
//   m_axis_dout_tvalid     one-cycle result strobe
//   m_axis_dout_tdata      {quotient, remainder} [2*WIDTH-1:0], held until next result
module axis_divider #(
  parameter int WIDTH = 32
) (
  input  logic               aclk,
  input  logic               rst,
  input  logic               s_axis_dividend_tvalid,
  input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
  input  logic               s_axis_divisor_tvalid,
  input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
  output logic               m_axis_dout_tvalid,
  output logic [2*WIDTH-1:0] m_axis_dout_tdata
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvs;
  logic             div_zero;

  logic             accept;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH:0]   rem_sh;
  logic             rem_ge;
  logic [WIDTH:0]   rem_diff;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

`ifdef DIVIDER_SIGNED_EN
  logic q_neg;
  logic r_neg;
`endif

  assign accept = (state == IDLE) && s_axis_dividend_tvalid && s_axis_divisor_tvalid;

  // The iteration runs on magnitudes; signs are reapplied once at the end.
`ifdef DIVIDER_SIGNED_EN
  assign dvd_mag = s_axis_dividend_tdata[WIDTH-1] ? -s_axis_dividend_tdata : s_axis_dividend_tdata;
  assign dvs_mag = s_axis_divisor_tdata[WIDTH-1]  ? -s_axis_divisor_tdata  : s_axis_divisor_tdata;
`else
  assign dvd_mag = s_axis_dividend_tdata;
  assign dvs_mag = s_axis_divisor_tdata;
`endif

  // Partial remainder shifted left with the next dividend bit from the top of quo.
  // Explicit compare keeps a zero divisor well behaved (every step "fits").
  assign rem_sh   = {rem, quo[WIDTH-1]};
  assign rem_ge   = (rem_sh >= {1'b0, dvs});
  assign rem_diff = rem_sh - {1'b0, dvs};

  // A zero divisor leaves rem equal to |dividend|, so the remainder sign fix
  // restores the original dividend; only the quotient needs overriding.
`ifdef DIVIDER_SIGNED_EN
  assign r_fix = r_neg ? -rem : rem;
  assign q_fix = div_zero ? {WIDTH{1'b1}} : (q_neg ? -quo : quo);
`else
  assign r_fix = rem;
  assign q_fix = div_zero ? {WIDTH{1'b1}} : quo;
`endif

  always_ff @(posedge aclk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt          = state;
    m_axis_dout_tvalid = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (cnt == LAST) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        m_axis_dout_tvalid = 1'b1;
        state_nxt          = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      cnt               <= '0;
      quo               <= '0;
      rem               <= '0;
      dvs               <= '0;
      div_zero          <= 1'b0;
      m_axis_dout_tdata <= '0;
`ifdef DIVIDER_SIGNED_EN
      q_neg             <= 1'b0;
      r_neg             <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt      <= '0;
            quo      <= dvd_mag;
            rem      <= '0;
            dvs      <= dvs_mag;
            div_zero <= (s_axis_divisor_tdata == '0);
`ifdef DIVIDER_SIGNED_EN
            q_neg    <= s_axis_dividend_tdata[WIDTH-1] ^ s_axis_divisor_tdata[WIDTH-1];
            r_neg    <= s_axis_dividend_tdata[WIDTH-1];
`endif
          end
        end
        BUSY: begin
          if (cnt == LAST) begin
            m_axis_dout_tdata <= {q_fix, r_fix};
          end else begin
            rem <= rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], rem_ge};
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_divider.sv
// tb/tb_axis_divider.sv - self-checking bench for axis_divider
module tb_axis_divider;

  logic        aclk;
  logic        rst;
  logic        dvd_valid;
  logic [31:0] dvd_data;
  logic        dvs_valid;
  logic [31:0] dvs_data;
  logic        dout_valid;
  logic [63:0] dout_data;

  int total;
  int bad;

  axis_divider #(.WIDTH(32)) dut (
    .aclk                   (aclk),
    .rst                    (rst),
    .s_axis_dividend_tvalid (dvd_valid),
    .s_axis_dividend_tdata  (dvd_data),
    .s_axis_divisor_tvalid  (dvs_valid),
    .s_axis_divisor_tdata   (dvs_data),
    .m_axis_dout_tvalid     (dout_valid),
    .m_axis_dout_tdata      (dout_data)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Reference: language division operators plus the two special cases.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    int sq;
    int sr;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
`ifdef DIVIDER_SIGNED_EN
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
    sa = int'(a);
    sb = int'(b);
    sq = sa / sb;
    sr = sa % sb;
    return {32'(sq), 32'(sr)};
`else
    sa = 0;
    sb = 0;
    sq = 0;
    sr = 0;
    return {a / b, a % b};
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one operation with both valids, scrambles tdata after acceptance,
  // keeps valids high through the DONE edge, then watches for stray pulses.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input string tag, input int watch);
    int first;
    int pulses;
    @(negedge aclk);
    dvd_data  = a;
    dvs_data  = b;
    dvd_valid = 1'b1;
    dvs_valid = 1'b1;
    first = 0;
    for (int i = 1; i <= 40 && first == 0; i++) begin
      @(negedge aclk);
      if (i == 1) begin
        dvd_data = $urandom;
        dvs_data = $urandom;
      end
      if (dout_valid) first = i;
    end
    check({tag, " latency"}, 64'(first), 64'd34);
    check({tag, " data"}, dout_data, exp);
    @(negedge aclk);
    check({tag, " pulse width"}, {63'd0, dout_valid}, 64'd0);
    dvd_valid = 1'b0;
    dvs_valid = 1'b0;
    pulses = 0;
    for (int i = 0; i < watch; i++) begin
      @(negedge aclk);
      if (dout_valid) pulses++;
    end
    check({tag, " no extra pulse"}, 64'(pulses), 64'd0);
    check({tag, " data held"}, dout_data, exp);
  endtask

  initial begin
    int pulses;
    logic [31:0] a;
    logic [31:0] b;
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    dvd_valid = 1'b0;
    dvs_valid = 1'b0;
    dvd_data  = 32'd0;
    dvs_data  = 32'd0;

    // Reset state
    repeat (2) @(negedge aclk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      if (dout_valid) pulses++;
    end
    check("reset tvalid", {63'd0, dout_valid}, 64'd0);
    check("reset tdata", dout_data, 64'd0);
    check("reset idle pulses", 64'(pulses), 64'd0);

    // 100 / 7, valids held past DONE: no re-accept
    run_op(32'd100, 32'd7, 64'h0000000E_00000002, "100/7", 36);

    // -7 / 2
`ifdef DIVIDER_SIGNED_EN
    run_op(32'hFFFF_FFF9, 32'd2, 64'hFFFFFFFD_FFFFFFFF, "-7/2", 2);
`else
    run_op(32'hFFFF_FFF9, 32'd2, 64'h7FFFFFFC_00000001, "-7/2", 2);
`endif

    // Divide by zero and signed overflow corner
    run_op(32'd5, 32'd0, 64'hFFFFFFFF_00000005, "5/0", 2);
`ifdef DIVIDER_SIGNED_EN
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 64'h80000000_00000000, "min/-1", 2);
    run_op(32'hFFFF_FFF0, 32'd0, 64'hFFFFFFFF_FFFFFFF0, "neg/0", 2);
`else
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, "min/max", 2);
    run_op(32'hFFFF_FFFF, 32'd1, 64'hFFFFFFFF_00000000, "max/1", 2);
`endif

    // One valid alone is ignored
    @(negedge aclk);
    dvd_data  = 32'd77;
    dvs_data  = 32'd4;
    dvd_valid = 1'b1;
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge aclk);
      if (dout_valid) pulses++;
    end
    check("single valid pulses", 64'(pulses), 64'd0);
    run_op(32'd77, 32'd4, 64'h00000013_00000001, "77/4 after single", 2);

    // Reset at E10 aborts
    @(negedge aclk);
    dvd_data  = 32'd1000;
    dvs_data  = 32'd3;
    dvd_valid = 1'b1;
    dvs_valid = 1'b1;
    for (int i = 1; i <= 10; i++) @(negedge aclk);
    rst       = 1'b1;
    dvd_valid = 1'b0;
    dvs_valid = 1'b0;
    @(negedge aclk);
    rst = 1'b0;
    check("abort tvalid", {63'd0, dout_valid}, 64'd0);
    check("abort tdata", dout_data, 64'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge aclk);
      if (dout_valid) pulses++;
    end
    check("abort pulses", 64'(pulses), 64'd0);
    run_op(32'd9, 32'd3, 64'h00000003_00000000, "9/3 after abort", 2);

    // Randomized operations against the reference model
    for (int n = 0; n < 30; n++) begin
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        3: b = a >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      run_op(a, b, model(a, b), "random", 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
